fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: decode control, instruction memory port and decode-register outputs
interface fetch_unit_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] Instr_F;
   logic [31:0] PC_F;
   logic        valid_F;

   modport master (
      input  stall, redirect, redirect_pc, im_rdata,
      output im_addr, Instr_F, PC_F, valid_F
   );

   modport slave (
      output stall, redirect, redirect_pc, im_rdata,
      input  im_addr, Instr_F, PC_F, valid_F
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with stall hold buffer and redirect squash
// Optional macro FETCH_DELAY_SLOT_EN keeps the instruction shown in the redirect cycle (delay slot).
module fetch_unit (
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  fe
);

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_out;
   logic [31:0] hold_instr, hold_instr_d;
   logic [31:0] hold_pc, hold_pc_d;
   logic [31:0] target;
   logic        take_redirect;

   assign target        = {fe.redirect_pc[31:2], 2'b00};
   assign take_redirect = fe.redirect && !fe.stall;
   assign fe.im_addr    = pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FILL;
         pc_q       <= RESET_PC;
         pc_out     <= RESET_PC;
         hold_instr <= 32'h0;
         hold_pc    <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_out     <= pc_q;
         hold_instr <= hold_instr_d;
         hold_pc    <= hold_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_instr_d = hold_instr;
      hold_pc_d    = hold_pc;
      fe.Instr_F   = 32'h0;
      fe.PC_F      = pc_out;
      fe.valid_F   = 1'b0;

      case (state_q)
         FILL: begin
            // Nothing valid to protect yet, so a stall does not hold the fetch here.
            if (take_redirect) begin
               pc_d = target;
            end else begin
               state_d = RUN;
               pc_d    = pc_q + 32'd4;
            end
         end
         RUN: begin
            fe.Instr_F = fe.im_rdata;
            fe.PC_F    = pc_out;
            fe.valid_F = 1'b1;
            if (fe.stall) begin
               state_d      = HOLD;
               hold_instr_d = fe.im_rdata;
               hold_pc_d    = pc_out;
            end else if (fe.redirect) begin
               state_d = FILL;
               pc_d    = target;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         HOLD: begin
            // pc_q is frozen here so im_rdata is already data(pc_q) when RUN resumes.
            fe.Instr_F = hold_instr;
            fe.PC_F    = hold_pc;
            fe.valid_F = 1'b1;
            if (!fe.stall) begin
               if (fe.redirect) begin
                  state_d = FILL;
                  pc_d    = target;
               end else begin
                  state_d = RUN;
                  pc_d    = pc_q + 32'd4;
               end
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

`ifdef FETCH_DELAY_SLOT_EN
`else
      if (take_redirect) begin
         fe.Instr_F = 32'h0;
         fe.valid_F = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit; memory word at A holds A
module tb_fetch_unit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .fe    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle synchronous instruction memory, word at A = A
   always @(posedge clk) bus.im_rdata <= bus.im_addr;

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic valid);
      expect_eq({tag, ".instr"}, bus.Instr_F, instr);
      expect_eq({tag, ".pc"},    bus.PC_F,    pc);
      expect_eq({tag, ".valid"}, {31'h0, bus.valid_F}, {31'h0, valid});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.im_rdata    = 32'h0;
      cyc();
      cyc();
      expect_out("reset", 32'h0, 32'h3000, 1'b0);
      expect_eq("reset.im_addr", bus.im_addr, 32'h3000);

      reset = 1'b0;
      #1;
      expect_out("post_reset", 32'h0, 32'h3000, 1'b0);
      expect_eq("post_reset.im_addr", bus.im_addr, 32'h3000);

      cyc();
      expect_out("seq0", 32'h3000, 32'h3000, 1'b1);
      expect_eq("seq0.im_addr", bus.im_addr, 32'h3004);
      cyc();
      expect_out("seq1", 32'h3004, 32'h3004, 1'b1);
      cyc();
      expect_out("seq2", 32'h3008, 32'h3008, 1'b1);

      for (int i = 0; i < 3; i++) begin
         bus.stall = 1'b1;
         #1;
         expect_out("stall", 32'h3008, 32'h3008, 1'b1);
         expect_eq("stall.im_addr", bus.im_addr, 32'h300C);
         cyc();
      end
      bus.stall = 1'b0;
      #1;
      expect_out("stall_rel", 32'h3008, 32'h3008, 1'b1);
      cyc();
      expect_out("after_stall", 32'h300C, 32'h300C, 1'b1);
      cyc();
      expect_out("pre_redir", 32'h3010, 32'h3010, 1'b1);

      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h3100;
      #1;
`ifdef FETCH_DELAY_SLOT_EN
      expect_out("redir_cycle", 32'h3010, 32'h3010, 1'b1);
`else
      expect_out("redir_cycle", 32'h0, 32'h3010, 1'b0);
`endif
      cyc();
      bus.redirect = 1'b0;
      #1;
      expect_eq("redir_bubble.valid", {31'h0, bus.valid_F}, 32'h0);
      expect_eq("redir_bubble.instr", bus.Instr_F, 32'h0);
      cyc();
      expect_out("redir_t0", 32'h3100, 32'h3100, 1'b1);
      cyc();
      expect_out("redir_t1", 32'h3104, 32'h3104, 1'b1);

      bus.stall       = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h3103;
      for (int i = 0; i < 2; i++) begin
         #1;
         expect_out("stall_redir", 32'h3104, 32'h3104, 1'b1);
         expect_eq("stall_redir.im_addr", bus.im_addr, 32'h3108);
         cyc();
      end
      bus.stall = 1'b0;
      #1;
`ifdef FETCH_DELAY_SLOT_EN
      expect_out("unstall_redir", 32'h3104, 32'h3104, 1'b1);
`else
      expect_out("unstall_redir", 32'h0, 32'h3104, 1'b0);
`endif
      expect_eq("unstall_redir.im_addr", bus.im_addr, 32'h3108);
      cyc();
      bus.redirect = 1'b0;
      #1;
      expect_eq("aligned_target.im_addr", bus.im_addr, 32'h3100);
      expect_eq("aligned_bubble.valid", {31'h0, bus.valid_F}, 32'h0);
      cyc();
      expect_out("aligned_t0", 32'h3100, 32'h3100, 1'b1);

      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      cyc();
      bus.redirect = 1'b0;
      #1;
      expect_eq("wrap_fill.im_addr", bus.im_addr, 32'hFFFF_FFFC);
      cyc();
      expect_out("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
      expect_eq("wrap.im_addr", bus.im_addr, 32'h0000_0000);
      cyc();
      expect_out("wrap_zero", 32'h0, 32'h0, 1'b1);
      expect_eq("wrap_zero.im_addr", bus.im_addr, 32'h4);

      bus.stall = 1'b1;
      cyc();
      expect_out("hold_pre_reset", 32'h0, 32'h0, 1'b1);
      reset = 1'b1;
      cyc();
      reset     = 1'b0;
      bus.stall = 1'b0;
      #1;
      expect_out("reset_in_hold", 32'h0, 32'h3000, 1'b0);
      expect_eq("reset_in_hold.im_addr", bus.im_addr, 32'h3000);
      cyc();
      expect_out("reset_in_hold_run", 32'h3000, 32'h3000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
